calc_core: RTL and testbench

Arithmetic and sequencing core of the keypad calculator. Sits between `keypad_driver` and `segment_driver` in the `sw_clk` domain. Consumes `keypad_driver` key codes (`eBCD`), runs operand entry and evaluation. Drives the signed 32-bit `fnd_serial` word that `segment_driver` renders, as either a decimal value or a special display code.

---
 rtl/calc_core_pkg.sv | 57 +++++
 rtl/calc_core_if.sv | 8 +
 rtl/calc_divider.sv | 62 ++++++
 rtl/calc_core.sv | 151 +++++++++++++++
 tb/tb_calc_core.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_core_pkg.sv
// Shared definitions for the keypad calculator: key codes, operator and state
// encodings, display codes and the small structs passed between core and divider.
package calc_core_pkg;

    localparam logic [4:0] KEY_9    = 5'h09;
    localparam logic [4:0] KEY_ADD  = 5'h0A;
    localparam logic [4:0] KEY_SUB  = 5'h0B;
    localparam logic [4:0] KEY_MUL  = 5'h0C;
    localparam logic [4:0] KEY_DIV  = 5'h0D;
    localparam logic [4:0] KEY_MOD  = 5'h0E;
    localparam logic [4:0] KEY_EQ   = 5'h0F;
    localparam logic [4:0] KEY_IDLE = 5'h1F;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam logic [31:0] DISP_ERR   = 32'h00EE_0000;
    localparam logic [31:0] DISP_HAPPY = 32'h00A0_0000;

    localparam logic [2:0] ST_ENTER_A  = 3'd0;
    localparam logic [2:0] ST_OP_SHOWN = 3'd1;
    localparam logic [2:0] ST_ENTER_B  = 3'd2;
    localparam logic [2:0] ST_EVAL     = 3'd3;
    localparam logic [2:0] ST_RESULT   = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    localparam int DEF_MAX_POS    = 999_999;
    localparam int DEF_MIN_NEG    = -99_999;
    localparam int DEF_DIV_CYCLES = 32;

    typedef struct packed {
        logic       vld;
        logic [4:0] code;
    } key_evt_t;

    typedef struct packed {
        logic [31:0] dividend;
        logic [31:0] divisor;
    } div_req_t;

    typedef struct packed {
        logic [31:0] quo;
        logic [31:0] rem;
    } div_rsp_t;

    // Operator display codes are 0x0010_0000 .. 0x0050_0000 in op order.
    function automatic logic [31:0] op_disp(input logic [2:0] op);
        logic [31:0] d;
        d        = '0;
        d[22:20] = op + 3'd1;
        return d;
    endfunction

endpackage

// File: rtl/calc_core_if.sv
// Keypad-to-display link of the calculator core: key code in, display word out.
interface calc_core_if;
    logic [4:0]         eBCD;
    logic signed [31:0] fnd_serial;

    modport master (output eBCD, input fnd_serial);
    modport slave  (input eBCD, output fnd_serial);
endinterface

// File: rtl/calc_divider.sv
// Restoring unsigned 32/32 divider, one quotient bit per cycle, start/done handshake.
import calc_core_pkg::*;

module calc_divider #(
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    input  div_req_t req,
    output logic     done,
    output div_rsp_t rsp
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [31:0]   dvs, rem, quo;
    logic [32:0]   shifted;
    logic [31:0]   diff;
    logic          ge;

    // When ge holds the true difference is below dvs, so the low 32 bits suffice.
    always_comb begin
        shifted = {rem, quo[31]};
        ge      = shifted >= {1'b0, dvs};
        diff    = shifted[31:0] - dvs;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            dvs  <= '0;
            rem  <= '0;
            quo  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= CW'(DIV_CYCLES);
                dvs  <= req.divisor;
                rem  <= '0;
                quo  <= req.dividend;
            end else if (busy) begin
                rem <= ge ? diff : shifted[31:0];
                quo <= {quo[30:0], ge};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign rsp.quo = quo;
    assign rsp.rem = rem;

endmodule

// File: rtl/calc_core.sv
// Calculator core: key-event detection, operand entry, evaluation and the
// registered display word for the segment driver.
import calc_core_pkg::*;

module calc_core #(
    parameter int MAX_POS    = DEF_MAX_POS,
    parameter int MIN_NEG    = DEF_MIN_NEG,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input logic        sw_clk,
    input logic        rst,
    calc_core_if.slave bus
);

    localparam logic signed [63:0] MAX64 = 64'(MAX_POS);
    localparam logic signed [63:0] MIN64 = 64'(MIN_NEG);

    logic [4:0]         prev;
    key_evt_t           evt;
    logic [2:0]         state, op;
    logic signed [31:0] acc_a, acc_b, fnd;

    logic               is_digit, is_op, is_eq, is_div;
    logic [2:0]         key_op;
    logic signed [31:0] edit;
    logic signed [63:0] entry_val, ext_a, ext_b, arith_res;
    logic [31:0]        mag_a, mag_b;
    logic signed [31:0] q_s, r_s, div_res;
    logic               div_start, div_done;
    div_req_t           div_req;
    div_rsp_t           div_rsp;

    function automatic logic in_range(input logic signed [63:0] v);
        return (v >= MIN64) && (v <= MAX64);
    endfunction

    always_comb begin
        is_digit  = evt.code <= KEY_9;
        is_op     = (evt.code >= KEY_ADD) && (evt.code <= KEY_MOD);
        is_eq     = evt.code == KEY_EQ;
        key_op    = evt.code[2:0] - 3'd2;
        is_div    = (op == OP_DIV) || (op == OP_MOD);
        edit      = (state == ST_ENTER_B) ? acc_b : acc_a;
        entry_val = 64'(edit) * 64'sd10 + $signed({60'd0, evt.code[3:0]});
        ext_a     = 64'(acc_a);
        ext_b     = 64'(acc_b);
        case (op)
            OP_ADD:  arith_res = ext_a + ext_b;
            OP_SUB:  arith_res = ext_a - ext_b;
            OP_MUL:  arith_res = ext_a * ext_b;
            default: arith_res = ext_a;
        endcase
        // Divider works on magnitudes; signs are restored here.
        mag_a   = acc_a[31] ? -acc_a : acc_a;
        mag_b   = acc_b[31] ? -acc_b : acc_b;
        q_s     = (acc_a[31] ^ acc_b[31]) ? -$signed(div_rsp.quo) : $signed(div_rsp.quo);
        r_s     = acc_a[31] ? -$signed(div_rsp.rem) : $signed(div_rsp.rem);
        div_res = (op == OP_MOD) ? r_s : q_s;
    end

    assign div_start = evt.vld && is_eq && (state == ST_ENTER_B) && is_div && (acc_b != 0);
    assign div_req.dividend = mag_a;
    assign div_req.divisor  = mag_b;

    calc_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk   (sw_clk),
        .rst   (rst),
        .start (div_start),
        .req   (div_req),
        .done  (div_done),
        .rsp   (div_rsp)
    );

    always_ff @(posedge sw_clk) begin
        if (!rst) begin
            prev  <= KEY_IDLE;
            evt   <= '0;
            state <= ST_ENTER_A;
            op    <= OP_ADD;
            acc_a <= '0;
            acc_b <= '0;
            fnd   <= DISP_HAPPY;
        end else begin
            prev     <= bus.eBCD;
            evt.vld  <= (prev == KEY_IDLE) && (bus.eBCD != KEY_IDLE);
            evt.code <= bus.eBCD;
            if (state == ST_EVAL) begin
                // Events arriving while the divider runs are dropped.
                if (div_done) begin
                    if (in_range(64'(div_res))) begin
                        acc_a <= div_res;
                        fnd   <= div_res;
                        state <= ST_RESULT;
                    end else begin
                        fnd   <= DISP_ERR;
                        state <= ST_ERROR;
                    end
                end
            end else if (evt.vld) begin
                if (is_digit) begin
                    case (state)
                        ST_ENTER_A: if (entry_val <= MAX64) begin
                            acc_a <= entry_val[31:0];
                            fnd   <= entry_val[31:0];
                        end
                        ST_ENTER_B: if (entry_val <= MAX64) begin
                            acc_b <= entry_val[31:0];
                            fnd   <= entry_val[31:0];
                        end
                        ST_OP_SHOWN: begin
                            acc_b <= {28'd0, evt.code[3:0]};
                            fnd   <= {28'd0, evt.code[3:0]};
                            state <= ST_ENTER_B;
                        end
                        default: begin
                            acc_a <= {28'd0, evt.code[3:0]};
                            fnd   <= {28'd0, evt.code[3:0]};
                            state <= ST_ENTER_A;
                        end
                    endcase
                end else if (is_op) begin
                    // From RESULT, acc_a already holds the result, so chaining is free.
                    if (state == ST_ENTER_A || state == ST_RESULT || state == ST_OP_SHOWN) begin
                        op    <= key_op;
                        fnd   <= op_disp(key_op);
                        state <= ST_OP_SHOWN;
                    end
                end else if (is_eq && state == ST_ENTER_B) begin
                    if (is_div) begin
                        if (acc_b == 0) begin
                            fnd   <= DISP_ERR;
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_EVAL;
                        end
                    end else if (in_range(arith_res)) begin
                        acc_a <= arith_res[31:0];
                        fnd   <= arith_res[31:0];
                        state <= ST_RESULT;
                    end else begin
                        fnd   <= DISP_ERR;
                        state <= ST_ERROR;
                    end
                end
            end
        end
    end

    assign bus.fnd_serial = fnd;

endmodule

// File: tb/tb_calc_core.sv
// Bench for calc_core: directed scenarios with timing checks, then random key
// streams compared against an arithmetic model of the calculator.
module tb_calc_core;
    import calc_core_pkg::*;

    localparam longint MAXP  = 999_999;
    localparam longint MINN  = -99_999;
    localparam longint HAPPY = 'h00A0_0000;
    localparam longint ERR   = 'h00EE_0000;

    localparam int M_A = 0, M_OPS = 1, M_B = 2, M_RES = 3, M_ERR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_core_if bus();

    calc_core dut (
        .sw_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int     m_mode, m_op;
    longint m_a, m_b, m_disp;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_disp = HAPPY;
    endtask

    task automatic model_key(input int code);
        longint r;
        if (code <= 9) begin
            case (m_mode)
                M_A: if (m_a * 10 + code <= MAXP) begin m_a = m_a * 10 + code; m_disp = m_a; end
                M_B: if (m_b * 10 + code <= MAXP) begin m_b = m_b * 10 + code; m_disp = m_b; end
                M_OPS: begin m_b = code; m_mode = M_B; m_disp = m_b; end
                default: begin m_a = code; m_mode = M_A; m_disp = m_a; end
            endcase
        end else if (code >= 10 && code <= 14) begin
            if (m_mode == M_A || m_mode == M_RES || m_mode == M_OPS) begin
                m_op = code - 10; m_mode = M_OPS; m_disp = longint'(m_op + 1) * 'h10_0000;
            end
        end else if (code == 15 && m_mode == M_B) begin
            if (m_op >= 3 && m_b == 0) begin
                m_mode = M_ERR; m_disp = ERR;
            end else begin
                case (m_op)
                    0: r = m_a + m_b;
                    1: r = m_a - m_b;
                    2: r = m_a * m_b;
                    3: r = m_a / m_b;
                    default: r = m_a % m_b;
                endcase
                if (r > MAXP || r < MINN) begin m_mode = M_ERR; m_disp = ERR; end
                else begin m_a = r; m_mode = M_RES; m_disp = r; end
            end
        end
    endtask

    // Raw key drive from a negedge; no model update.
    task automatic drive(input logic [4:0] code, input int hold, input int gap);
        bus.eBCD = code;
        repeat (hold) @(negedge clk);
        bus.eBCD = KEY_IDLE;
        repeat (gap) @(negedge clk);
    endtask

    // Press a key, check the settled display and how many times it changed.
    task automatic kp(input logic [4:0] code, input longint exp, input int exp_chg, input string tag);
        longint last;
        int     nchg;
        last = bus.fnd_serial; nchg = 0;
        bus.eBCD = code;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.fnd_serial != last) begin nchg++; last = bus.fnd_serial; end
            if (i == 4) bus.eBCD = KEY_IDLE;
        end
        model_key(int'(code));
        chk(tag, bus.fnd_serial, exp);
        chk({tag, "_nupd"}, nchg, exp_chg);
    endtask

    // Press a key and measure the edge offset at which the display first changes.
    task automatic timed(input logic [4:0] code, input int exp_lat, input longint exp, input string tag);
        longint old;
        int     lat;
        old = bus.fnd_serial; lat = -1;
        bus.eBCD = code;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (lat < 0 && bus.fnd_serial != old) lat = k;
            if (k == 4) bus.eBCD = KEY_IDLE;
        end
        model_key(int'(code));
        chk({tag, "_lat"}, lat, exp_lat);
        chk(tag, bus.fnd_serial, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, code, hold, gap;
        bus.eBCD = KEY_IDLE;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_happy", bus.fnd_serial, HAPPY);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_happy", bus.fnd_serial, HAPPY);

        // 12 + 3 = 15, one update per held key
        kp(5'h01, 1, 1, "t1_d1");
        kp(5'h02, 12, 1, "t1_d2");
        kp(KEY_ADD, 'h10_0000, 1, "t1_add");
        kp(5'h03, 3, 1, "t1_d3");
        timed(KEY_EQ, 1, 15, "t1_eq");

        // 7 - 9 = -2, then chained * 5 = -10
        kp(5'h07, 7, 1, "t2_d7");
        kp(KEY_SUB, 'h20_0000, 1, "t2_sub");
        kp(5'h09, 9, 1, "t2_d9");
        timed(KEY_EQ, 1, -2, "t2_eq");
        kp(KEY_MUL, 'h30_0000, 1, "t2_mul");
        kp(5'h05, 5, 1, "t2_d5");
        timed(KEY_EQ, 1, -10, "t2_chain");

        // division and mod latency, signed mod
        kp(5'h01, 1, 1, "t3_d1");
        kp(5'h07, 17, 1, "t3_d7");
        kp(KEY_DIV, 'h40_0000, 1, "t3_div");
        kp(5'h05, 5, 1, "t3_d5");
        timed(KEY_EQ, 34, 3, "t3_q");
        kp(5'h07, 7, 1, "t3_m7");
        kp(5'h01, 71, 1, "t3_m1");
        kp(KEY_MOD, 'h50_0000, 1, "t3_mod");
        kp(5'h05, 5, 1, "t3_m5");
        timed(KEY_EQ, 34, 1, "t3_r");
        kp(5'h00, 0, 1, "t3_z");
        kp(KEY_SUB, 'h20_0000, 1, "t3_sub");
        kp(5'h01, 1, 1, "t3_n1");
        kp(5'h07, 17, 1, "t3_n7");
        timed(KEY_EQ, 1, -17, "t3_neg");
        kp(KEY_MOD, 'h50_0000, 1, "t3_mod2");
        kp(5'h05, 5, 1, "t3_n5");
        timed(KEY_EQ, 34, -2, "t3_negmod");

        // divide by zero
        kp(5'h09, 9, 1, "t4_d9");
        kp(KEY_DIV, 'h40_0000, 1, "t4_div");
        kp(5'h00, 0, 1, "t4_d0");
        timed(KEY_EQ, 1, ERR, "t4_dz");
        kp(5'h04, 4, 1, "t4_after");

        // range limits
        kp(KEY_ADD, 'h10_0000, 1, "t5_add0");
        kp(5'h00, 0, 1, "t5_z");
        timed(KEY_EQ, 1, 4, "t5_four");
        for (int i = 0; i < 6; i++) kp(5'h09, (MAXP * 10 + 9) / (64'd10 ** (6 - i)) , 1, "t5_nines");
        kp(5'h09, MAXP, 0, "t5_seventh");
        kp(KEY_ADD, 'h10_0000, 1, "t5_add");
        kp(5'h01, 1, 1, "t5_one");
        timed(KEY_EQ, 1, ERR, "t5_ovf");
        for (int i = 0; i < 3; i++) kp(5'h09, (64'd10 ** (i + 1)) - 1, 1, "t5_a999");
        kp(KEY_MUL, 'h30_0000, 1, "t5_mul");
        for (int i = 0; i < 3; i++) kp(5'h09, (64'd10 ** (i + 1)) - 1, 1, "t5_b999");
        timed(KEY_EQ, 1, 998_001, "t5_prod");

        // code-to-code change, invalid code, operator ignored in ENTER_B
        bus.eBCD = 5'h03;
        repeat (3) @(negedge clk);
        drive(5'h05, 3, 3);
        model_key(3);
        chk("t6_direct", bus.fnd_serial, 3);
        drive(5'h15, 3, 3);
        chk("t6_invalid", bus.fnd_serial, 3);
        kp(KEY_ADD, 'h10_0000, 1, "t6_add");
        kp(5'h02, 2, 1, "t6_d2");
        kp(KEY_MUL, 2, 0, "t6_op_in_b");
        timed(KEY_EQ, 1, 5, "t6_sum");

        // reset during a divide
        kp(5'h08, 8, 1, "t7_d8");
        kp(KEY_DIV, 'h40_0000, 1, "t7_div");
        kp(5'h02, 2, 1, "t7_d2");
        drive(KEY_EQ, 4, 6);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (40) @(negedge clk);
        chk("t7_abort", bus.fnd_serial, HAPPY);

        // key during EVAL is dropped
        kp(5'h08, 8, 1, "t7_e8");
        kp(KEY_DIV, 'h40_0000, 1, "t7_ediv");
        kp(5'h02, 2, 1, "t7_e2");
        drive(KEY_EQ, 4, 6);
        model_key(15);
        drive(5'h05, 4, 40);
        chk("t7_drop", bus.fnd_serial, 4);
        kp(KEY_ADD, 'h10_0000, 1, "t7_add");
        kp(5'h01, 1, 1, "t7_one");
        timed(KEY_EQ, 1, 5, "t7_chain");

        // random key streams against the model
        do_reset();
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      code = int'($urandom_range(0, 9));
            else if (r < 80) code = int'($urandom_range(10, 14));
            else if (r < 92) code = 15;
            else             code = int'($urandom_range(16, 30));
            hold = int'($urandom_range(1, 6));
            gap  = (code == 15) ? 40 : int'($urandom_range(1, 4));
            drive(5'(code), hold, gap);
            model_key(code);
            chk("rand", bus.fnd_serial, m_disp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
